// File: rtl/counter_ctrl.sv
// Button front end for the up/down counter: synchronizes and debounces three
// raw buttons, toggles down/step/run on each press, and ticks en while running.
module counter_ctrl #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned DIV       = 8
) (
  input  logic clk,
  input  logic nrst,
  input  logic btn_dir,
  input  logic btn_step,
  input  logic btn_run,
  output logic down,
  output logic step,
  output logic en,
  output logic run
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DB_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

  // Bit order everywhere: [0] dir, [1] step, [2] run.
  logic [2:0]    btn;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    s;
  logic [2:0]    s_d;
  logic [2:0]    press;
  logic [CW-1:0] c [3];
  logic [PW-1:0] p;
  logic          run_nxt;

  assign btn = {btn_run, btn_step, btn_dir};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s   <= '0;
      s_d <= '0;
      for (int unsigned i = 0; i < 3; i++) c[i] <= '0;
    end else begin
      s_d <= s;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == s[i]) begin
          c[i] <= '0;
        end else if (c[i] == C_LAST) begin
          s[i] <= sync2[i];
          c[i] <= '0;
        end else begin
          c[i] <= c[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    press   = s & ~s_d;
    run_nxt = run ^ press[2];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      down <= 1'b0;
      step <= 1'b0;
      run  <= 1'b0;
    end else begin
      down <= down ^ press[0];
      step <= step ^ press[1];
      run  <= run_nxt;
    end
  end

  // Count only while run is on both before and after this edge: turning off
  // clears p/en on the same edge, turning on starts p from 0 next cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      p  <= '0;
      en <= 1'b0;
    end else if (!(run && run_nxt)) begin
      p  <= '0;
      en <= 1'b0;
    end else if (p == P_LAST) begin
      p  <= '0;
      en <= 1'b1;
    end else begin
      p  <= p + PW'(1);
      en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed scenarios with literal expectations plus
// randomized button activity checked every cycle against a behavioural model.
module tb_counter_ctrl;

  localparam int DB = 4;
  localparam int DV = 8;

  logic clk      = 1'b0;
  logic nrst     = 1'b1;
  logic btn_dir  = 1'b0;
  logic btn_step = 1'b0;
  logic btn_run  = 1'b0;
  logic down, step, en, run;

  int checks = 0;
  int errors = 0;

  counter_ctrl #(.DB_CYCLES(DB), .DIV(DV)) dut (
    .clk(clk), .nrst(nrst),
    .btn_dir(btn_dir), .btn_step(btn_step), .btn_run(btn_run),
    .down(down), .step(step), .en(en), .run(run)
  );

  always #5 clk = ~clk;

  // Model: a raw level reaches the debouncer two edges late; it is accepted
  // once it has disagreed with the stable value for DB samples in a row.
  logic [2:0] m_s1 = '0, m_s2 = '0, m_s = '0, m_sd = '0, m_pr;
  int         m_diff [3] = '{0, 0, 0};
  logic       m_down = 0, m_step = 0, m_run = 0, m_en = 0, m_run_old;
  int         m_since = 0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_s1 = '0; m_s2 = '0; m_s = '0; m_sd = '0;
      for (int i = 0; i < 3; i++) m_diff[i] = 0;
      m_down = 0; m_step = 0; m_run = 0; m_en = 0; m_since = 0;
    end else begin
      m_pr      = m_s & ~m_sd;
      m_run_old = m_run;
      m_down    = m_down ^ m_pr[0];
      m_step    = m_step ^ m_pr[1];
      m_run     = m_run ^ m_pr[2];
      // en fires every DV edges counted from the edge on which run rose
      if (m_run && m_run_old) begin
        m_since = m_since + 1;
        m_en    = (m_since % DV) == 0;
      end else begin
        m_since = 0;
        m_en    = 0;
      end
      m_sd = m_s;
      for (int i = 0; i < 3; i++) begin
        if (m_s2[i] != m_s[i]) begin
          m_diff[i] = m_diff[i] + 1;
          if (m_diff[i] == DB) begin
            m_s[i]    = m_s2[i];
            m_diff[i] = 0;
          end
        end else begin
          m_diff[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = {btn_run, btn_step, btn_dir};
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("model_down", down, m_down);
      chk("model_step", step, m_step);
      chk("model_run",  run,  m_run);
      chk("model_en",   en,   m_en);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_down"}, down, 1'b0);
    chk({name, "_step"}, step, 1'b0);
    chk({name, "_run"},  run,  1'b0);
    chk({name, "_en"},   en,   1'b0);
  endtask

  initial begin
    #1 nrst = 1'b0;
    #3 chk_all_zero("reset");
    @(negedge clk);
    nrst = 1'b1;
    for (int e = 0; e < 50; e++) begin
      cyc(1);
      chk_all_zero("idle");
    end

    // Held dir press: toggles at edge 6 and only once
    btn_dir = 1'b1;
    for (int e = 0; e < 20; e++) begin
      cyc(1);
      chk("dir_press", down, e >= 6);
    end
    btn_dir = 1'b0;
    cyc(12);
    btn_dir = 1'b1;
    cyc(20);
    chk("dir_second_press", down, 1'b0);
    btn_dir = 1'b0;
    cyc(12);

    // Glitch of 3 cycles rejected, 4 cycles accepted
    btn_step = 1'b1;
    cyc(3);
    btn_step = 1'b0;
    cyc(12);
    chk("step_glitch", step, 1'b0);
    btn_step = 1'b1;
    cyc(4);
    btn_step = 1'b0;
    cyc(12);
    chk("step_min_press", step, 1'b1);

    // Run on: first en 8 cycles after run rises, then every 8
    btn_run = 1'b1;
    for (int e = 0; e < 31; e++) begin
      cyc(1);
      chk("run_on", run, e >= 6);
      chk("en_period", en, (e >= 14) && ((e - 14) % DV == 0));
    end
    btn_run = 1'b0;
    cyc(12);
    btn_run = 1'b1;
    for (int e = 0; e < 20; e++) begin
      cyc(1);
      chk("run_off", run, e < 6);
      if (e >= 6) chk("en_off", en, 1'b0);
    end
    btn_run = 1'b0;
    cyc(12);

    // Simultaneous dir and step presses (down 0->1, step 1->0)
    btn_dir  = 1'b1;
    btn_step = 1'b1;
    for (int e = 0; e < 10; e++) begin
      cyc(1);
      chk("simul_down", down, e >= 6);
      chk("simul_step", step, e < 6);
    end
    btn_dir  = 1'b0;
    btn_step = 1'b0;
    cyc(12);

    // Build down=1, step=1, run=1, p=5, then reset between edges
    btn_step = 1'b1;
    cyc(8);
    btn_step = 1'b0;
    cyc(12);
    btn_run = 1'b1;
    cyc(12);
    chk("pre_reset_down", down, 1'b1);
    chk("pre_reset_step", step, 1'b1);
    chk("pre_reset_run",  run,  1'b1);
    btn_run = 1'b0;
    #2 nrst = 1'b0;
    #1 chk_all_zero("async_reset");
    #1 nrst = 1'b1;
    for (int e = 0; e < 30; e++) begin
      cyc(1);
      chk_all_zero("post_reset");
    end

    // Random button activity with occasional mid-cycle resets
    for (int e = 0; e < 3000; e++) begin
      if ($urandom_range(0, 5) == 0) btn_dir  = ~btn_dir;
      if ($urandom_range(0, 5) == 0) btn_step = ~btn_step;
      if ($urandom_range(0, 7) == 0) btn_run  = ~btn_run;
      if ($urandom_range(0, 399) == 0) begin
        #2 nrst = 1'b0;
        #1 chk_all_zero("rand_reset");
        #1 nrst = 1'b1;
      end
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
